// File: rtl/div_seq.sv
// Iterative restoring divider for EX: one quotient bit per cycle, result WIDTH+1 cycles after start (1 for fast divide-by-zero).
// Backpressure: stall_req holds EX and earlier stages from the start cycle through the last iteration; flush abandons the operation.
module div_seq #(
  parameter int WIDTH     = 32,
  parameter bit FAST_ZERO = 1'b1,
  parameter int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_div,
  input  logic             op_divu,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             stall_req,
  output logic             result_valid,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic             sgn;
    logic             sign_q;
    logic             sign_r;
    logic             zero;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] b_mag;
  } op_t;

  state_t           state_q, state_d;
  op_t              op_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dbz_q;

  logic             start;
  logic             last;
  logic             zero_in;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             take;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign start   = (op_div | op_divu) & ~flush;
  assign last    = (cnt_q == CNT_W'(WIDTH - 1));
  assign zero_in = (src_b == '0);

  // op_div wins when both requests are raised, so it alone selects signed mode
  assign a_mag = (op_div & src_a[WIDTH-1]) ? -src_a : src_a;
  assign b_mag = (op_div & src_b[WIDTH-1]) ? -src_b : src_b;

  // quo_q starts as |a| and shifts dividend bits out of its top while quotient bits enter at the bottom
  assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
  assign take    = (rem_sh >= {1'b0, op_q.b_mag});
  assign rem_sub = rem_sh[WIDTH-1:0] - op_q.b_mag;
  assign rem_nxt = take ? rem_sub : rem_sh[WIDTH-1:0];
  assign quo_nxt = {quo_q[WIDTH-2:0], take};

  assign q_fix = (op_q.sgn & op_q.sign_q) ? -quo_nxt : quo_nxt;
  assign r_fix = (op_q.sgn & op_q.sign_r) ? -rem_nxt : rem_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    stall_req    = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          stall_req = 1'b1;
          state_d   = (zero_in && FAST_ZERO) ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall_req = ~flush;
        if (last) state_d = DONE;
      end
      DONE: begin
        result_valid = ~flush;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
    if (rst) begin
      stall_req    = 1'b0;
      result_valid = 1'b0;
    end
  end

  assign div_by_zero = result_valid & dbz_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      hi    <= '0;
      lo    <= '0;
      dbz_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      op_q.sgn    <= op_div;
      op_q.sign_q <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
      op_q.sign_r <= src_a[WIDTH-1];
      op_q.zero   <= zero_in;
      op_q.a_raw  <= src_a;
      op_q.b_mag  <= b_mag;
      rem_q       <= '0;
      quo_q       <= a_mag;
      cnt_q       <= '0;
      if (zero_in && FAST_ZERO) begin
        lo    <= '1;
        hi    <= src_a;
        dbz_q <= 1'b1;
      end
    end else if (state_q == BUSY && !flush) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt_q <= cnt_q + 1'b1;
      if (last) begin
        dbz_q <= op_q.zero;
        if (op_q.zero) begin
          lo <= '1;
          hi <= op_q.a_raw;
        end else begin
          lo <= q_fix;
          hi <= r_fix;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: a FAST_ZERO and a full-latency instance share stimulus; expected results queue up at start and are popped on result_valid.
module tb_div_seq;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dbz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         op_div = 1'b0;
  logic         op_divu = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;

  logic         stall_f, rv_f, dbz_f, stall_s, rv_s, dbz_s;
  logic [W-1:0] lo_f, hi_f, lo_s, hi_s;

  bit           use_slow = 1'b0;
  logic         stall, rv, dbz;
  logic [W-1:0] lo, hi;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  assign stall = use_slow ? stall_s : stall_f;
  assign rv    = use_slow ? rv_s    : rv_f;
  assign dbz   = use_slow ? dbz_s   : dbz_f;
  assign lo    = use_slow ? lo_s    : lo_f;
  assign hi    = use_slow ? hi_s    : hi_f;

  always #5 clk = ~clk;

  div_seq #(.WIDTH(W), .FAST_ZERO(1'b1)) dut_fast (
    .clk(clk), .rst(rst), .op_div(op_div), .op_divu(op_divu),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .stall_req(stall_f), .result_valid(rv_f), .lo(lo_f), .hi(hi_f),
    .div_by_zero(dbz_f)
  );

  div_seq #(.WIDTH(W), .FAST_ZERO(1'b0)) dut_slow (
    .clk(clk), .rst(rst), .op_div(op_div), .op_divu(op_divu),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .stall_req(stall_s), .result_valid(rv_s), .lo(lo_s), .hi(hi_s),
    .div_by_zero(dbz_s)
  );

  function automatic exp_t model(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb_v, q, r;
    if (b == '0) begin
      e.lo  = '1;
      e.hi  = a;
      e.dbz = 1'b1;
    end else if (sgn) begin
      sa    = $signed(a);
      sb_v  = $signed(b);
      q     = sa / sb_v;
      r     = sa % sb_v;
      e.lo  = q[W-1:0];
      e.hi  = r[W-1:0];
      e.dbz = 1'b0;
    end else begin
      e.lo  = a / b;
      e.hi  = a % b;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 once both instances are idle again.
  task automatic run_div(input bit sd, input bit du, input bit hold,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input exp_t e, input int exp_lat, input string name);
    int   cyc;
    int   stalls;
    bit   got;
    bit   extra;
    exp_t ex;
    op_div  = sd;
    op_divu = du;
    src_a   = a;
    src_b   = b;
    sb.push_back(e);
    cyc = 0; stalls = 0; got = 0; extra = 0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      if (rv) begin
        got = 1;
        n_vec++;
        if (cyc !== exp_lat) begin
          n_err++;
          $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
        end
        n_vec++;
        if (stall !== 1'b0) begin
          n_err++;
          $display("FAIL %s stall_in_done: got %b want 0", name, stall);
        end
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL %s unexpected_result: got result_valid want none", name);
        end else begin
          ex = sb.pop_front();
          n_vec++;
          if (lo !== ex.lo) begin
            n_err++;
            $display("FAIL %s lo: got %h want %h", name, lo, ex.lo);
          end
          n_vec++;
          if (hi !== ex.hi) begin
            n_err++;
            $display("FAIL %s hi: got %h want %h", name, hi, ex.hi);
          end
          n_vec++;
          if (dbz !== ex.dbz) begin
            n_err++;
            $display("FAIL %s div_by_zero: got %b want %b", name, dbz, ex.dbz);
          end
        end
      end else if (stall) begin
        stalls++;
      end
      @(posedge clk); #1;
      if (!hold || got) begin
        op_div  = 1'b0;
        op_divu = 1'b0;
      end
      cyc++;
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL %s timeout: got no result_valid want one within 100 cycles", name);
      while (sb.size() > 0) ex = sb.pop_front();
    end
    n_vec++;
    if (stalls !== exp_lat) begin
      n_err++;
      $display("FAIL %s stall_cycles: got %0d want %0d", name, stalls, exp_lat);
    end
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (rv) extra = 1;
      if (i >= 2 && !stall_f && !stall_s) break;
    end
    @(posedge clk); #1;
    n_vec++;
    if (extra) begin
      n_err++;
      $display("FAIL %s extra_result: got additional result_valid want exactly one", name);
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({stall_f, rv_f, dbz_f, stall_s, rv_s, dbz_s} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 000000", {stall_f, rv_f, dbz_f, stall_s, rv_s, dbz_s});
    end
    n_vec++;
    if ({hi_f, lo_f, hi_s, lo_s} !== '0) begin
      n_err++;
      $display("FAIL reset_hilo: got %h %h %h %h want 0", hi_f, lo_f, hi_s, lo_s);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_divu_basic();
    run_div(0, 1, 0, 32'd100, 32'd7, '{lo: 32'd14, hi: 32'd2, dbz: 1'b0}, 33, "divu_100_7");
  endtask

  task automatic test_signed();
    run_div(1, 0, 0, 32'hFFFF_FFF9, 32'd2, '{lo: 32'hFFFF_FFFD, hi: 32'hFFFF_FFFF, dbz: 1'b0}, 33, "div_m7_2");
    run_div(0, 1, 0, 32'hFFFF_FFF9, 32'd2, '{lo: 32'h7FFF_FFFC, hi: 32'd1, dbz: 1'b0}, 33, "divu_m7_2");
    run_div(1, 0, 0, 32'd100, 32'hFFFF_FFF9, '{lo: 32'hFFFF_FFF2, hi: 32'd2, dbz: 1'b0}, 33, "div_100_m7");
  endtask

  task automatic test_overflow();
    run_div(1, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, '{lo: 32'h8000_0000, hi: 32'd0, dbz: 1'b0}, 33, "div_minneg");
    run_div(0, 1, 0, 32'hFFFF_FFFF, 32'd2, '{lo: 32'h7FFF_FFFF, hi: 32'd1, dbz: 1'b0}, 33, "divu_max_2");
  endtask

  task automatic test_zero();
    use_slow = 1'b0;
    run_div(0, 1, 0, 32'h1234, 32'd0, '{lo: 32'hFFFF_FFFF, hi: 32'h1234, dbz: 1'b1}, 1, "zero_fast");
    run_div(1, 0, 0, 32'hFFFF_FF00, 32'd0, '{lo: 32'hFFFF_FFFF, hi: 32'hFFFF_FF00, dbz: 1'b1}, 1, "zero_fast_signed");
    use_slow = 1'b1;
    run_div(0, 1, 0, 32'h1234, 32'd0, '{lo: 32'hFFFF_FFFF, hi: 32'h1234, dbz: 1'b1}, 33, "zero_slow");
    run_div(1, 0, 0, 32'hFFFF_FF00, 32'd0, '{lo: 32'hFFFF_FFFF, hi: 32'hFFFF_FF00, dbz: 1'b1}, 33, "zero_slow_signed");
    use_slow = 1'b0;
  endtask

  task automatic test_flush();
    logic [W-1:0] hi0, lo0;
    hi0 = hi;
    lo0 = lo;
    op_divu = 1'b1;
    src_a   = 32'd1000;
    src_b   = 32'd3;
    repeat (10) begin
      @(posedge clk); #1;
      op_divu = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL flush_stall: got %b want 0", stall);
    end
    n_vec++;
    if (rv !== 1'b0) begin
      n_err++;
      $display("FAIL flush_valid: got %b want 0", rv);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    n_vec++;
    if (hi !== hi0 || lo !== lo0) begin
      n_err++;
      $display("FAIL flush_hilo: got %h/%h want %h/%h", hi, lo, hi0, lo0);
    end
    run_div(1, 0, 0, -32'sd100, 32'd7, model(1, -32'sd100, 32'd7), 33, "div_after_flush");
  endtask

  task automatic test_flush_start();
    bit seen;
    seen    = 0;
    op_div  = 1'b1;
    src_a   = 32'd50;
    src_b   = 32'd5;
    flush   = 1'b1;
    @(negedge clk);
    if (stall) seen = 1;
    @(posedge clk); #1;
    op_div = 1'b0;
    flush  = 1'b0;
    repeat (36) begin
      @(negedge clk);
      if (stall || rv) seen = 1;
    end
    @(posedge clk); #1;
    n_vec++;
    if (seen) begin
      n_err++;
      $display("FAIL flush_start: got stall/result activity want none");
    end
  endtask

  task automatic test_hold_both();
    run_div(1, 1, 1, 32'hFFFF_FFF9, 32'd2, '{lo: 32'hFFFF_FFFD, hi: 32'hFFFF_FFFF, dbz: 1'b0}, 33, "both_held");
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen    = 0;
    op_div  = 1'b1;
    op_divu = 1'b1;
    src_a   = 32'd999;
    src_b   = 32'd4;
    @(posedge clk); #1;
    op_div  = 1'b0;
    op_divu = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({stall_f, rv_f, stall_s, rv_s} !== 4'b0) begin
      n_err++;
      $display("FAIL rst_mid_ctrl: got %b want 0000", {stall_f, rv_f, stall_s, rv_s});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if ({hi_f, lo_f, hi_s, lo_s} !== '0) begin
      n_err++;
      $display("FAIL rst_mid_hilo: got %h %h %h %h want 0", hi_f, lo_f, hi_s, lo_s);
    end
    repeat (40) begin
      @(negedge clk);
      if (rv_f || rv_s || stall_f || stall_s) seen = 1;
    end
    @(posedge clk); #1;
    n_vec++;
    if (seen) begin
      n_err++;
      $display("FAIL rst_mid_quiet: got activity after reset want none");
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    bit           sgn;
    for (int i = 0; i < 8; i++) begin
      a   = $urandom;
      b   = (i % 3 == 0) ? W'($urandom_range(1, 15)) : W'($urandom);
      if (b == '0) b = 32'd1;
      sgn = 1'($urandom_range(0, 1));
      run_div(sgn, ~sgn, 0, a, b, model(sgn, a, b), 33, "random");
    end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_overflow();
    test_zero();
    test_flush();
    test_flush_start();
    test_hold_both();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Parametrised iterative divider with integrated pipeline control for the MIPS datapath; successor to the combinational divider-control decode.
- Sits in EX. Accepts DIV/DIVU, holds the pipeline through `stall_req` while iterating one quotient bit per cycle, and delivers the quotient (LO) and remainder (HI) with a one-cycle `result_valid` strobe.
- Handles flush/annul and divide-by-zero internally, so no separate start/signed/annul decode is needed.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4).
- FAST_ZERO, 1, 1: divide-by-zero finishes in 1 cycle; 0: takes the full WIDTH iterations.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- op_div  in  1  signed divide request from EX
- op_divu  in  1  unsigned divide request from EX
- src_a  in  WIDTH  dividend
- src_b  in  WIDTH  divisor
- flush  in  1  pipeline flush (exception/annul), highest priority after rst
- stall_req  out  1  hold EX and earlier stages
- result_valid  out  1  one-cycle strobe; hi/lo updated this cycle
- lo  out  WIDTH  quotient, registered
- hi  out  WIDTH  remainder, registered
- div_by_zero  out  1  qualifies result_valid; divisor was 0

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; hi=0, lo=0, counter=0, latched operands=0.
  - result_valid=0, div_by_zero=0, stall_req forced 0 during the rst cycle.
  - Reset mid-operation abandons it with no result.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Start condition is (op_div|op_divu) & ~flush. On start:
    - Latch the signed flag (op_div wins if both are high).
    - Latch |a| and |b| (magnitude only when signed), sign_q = a[MSB]^b[MSB] and sign_r = a[MSB] (signed only).
    - Set the zero flag (b==0) and clear the counter.
  - stall_req = start, combinational, in the same cycle.
  - Next state: BUSY, or DONE if zero & FAST_ZERO.
- BUSY:
  - Restoring division, one step per cycle: shift partial remainder left by 1 and bring in the next dividend bit (MSB first); if remainder ≥ |b|, subtract and set the quotient bit.
  - counter increments each cycle; stall_req=1.
  - After the WIDTH-th step, go to DONE.
  - Request inputs are ignored while BUSY.
- DONE:
  - stall_req=0 and result_valid=1 (gated by ~flush).
  - hi/lo are loaded at the edge entering DONE, so they are valid during the DONE cycle.
  - op inputs are ignored in DONE; the same instruction leaves EX at the end of this cycle and is never restarted.
  - Next state is always IDLE.
- Latency from the start cycle T:
  - stall_req high T..T+WIDTH; result_valid at T+WIDTH+1.
  - FAST_ZERO divide-by-zero: stall_req at T only, result_valid at T+1.
  - Back-to-back divides: the second starts no earlier than the cycle after DONE.
- Sign fix-up when loading hi/lo:
  - lo = sign_q ? −q : q; hi = sign_r ? −r : r; both WIDTH-bit, truncating.
  - Most-negative / −1 gives lo = 0x80..0, hi = 0 with no trap.
- Divide by zero (either mode):
  - lo = all ones, hi = src_a as latched (raw, not magnitude); div_by_zero=1 alongside result_valid.
  - With FAST_ZERO=0 the latency is the normal one and the result is the same.
- Flush:
  - In any state, flush forces state=IDLE at the next edge; hi/lo keep their previous values.
  - result_valid is suppressed in the flush cycle; stall_req is 0 in the flush cycle.
  - A flush in the IDLE start cycle prevents the start.
- rst takes priority over flush; flush takes priority over start.

Test Plan:
- DIVU 100/7 -> stall_req high 33 cycles (WIDTH=32); result_valid one cycle at T+33; lo=14, hi=2, div_by_zero=0.
- DIV 0xFFFFFFF9 (−7) / 2 -> lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1); the same operands via DIVU -> lo=0x7FFFFFFC, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU 0xFFFFFFFF/2 -> lo=0x7FFFFFFF, hi=1.
- Divide by zero, src_a=0x1234 -> FAST_ZERO=1: result_valid at T+1, lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1; FAST_ZERO=0: the same values at T+33.
- Flush in BUSY at T+10 -> IDLE at T+11, stall_req=0, no result_valid, hi/lo unchanged; a new DIV at T+11 starts and completes correctly.
- Both op_div and op_divu held through DONE, plus rst asserted mid-BUSY -> exactly one result per start (no restart in DONE); rst clears hi/lo to 0 with no result_valid.
